tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//   Time-division demultiplexer and the sequential counterpart of the mux2 datapath.
//   It accepts one word stream on a valid/ready input and distributes successive
//   words round-robin across N_LANES output lanes.
//   Each lane has a one-entry holding register with its own valid/ready handshake.
//   The block sits between a serialised producer and N parallel lane consumers.
// PARAMETERS
//   N_LANES  4  number of output lanes; must be >= 2; need not be a power of two
//   WIDTH    8  bits per data word
//   SEL_W    $clog2(N_LANES)  lane pointer width; derived, not overridden
// PORTS
//   clk         in   1              single clock, rising edge
//   rst         in   1              synchronous, active-high reset
//   ena         in   1              global enable; 0 blocks input, output drain continues
//   in_data     in   WIDTH          input word
//   in_valid    in   1              producer has a word
//   in_ready    out  1              block accepts in_data this cycle
//   out_data    out  N_LANES*WIDTH  lane k word at [k*WIDTH +: WIDTH]
//   out_valid   out  N_LANES        lane k holds an unconsumed word
//   out_ready   in   N_LANES        consumer k takes its word this cycle
//   sel         out  SEL_W          lane that receives the next accepted word
//   frame_done  out  1              one-cycle pulse after a word is accepted into lane N_LANES-1
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - out_valid=0, out_data=0, sel=0, frame_done=0.
//     - Held words are discarded, including a reset mid-frame.
//     - in_ready is combinational and has no reset value of its own.
//   Input handshake (combinational ready):
//     - in_ready = ena & (~out_valid[sel] | out_ready[sel]).
//     - accept = in_valid & in_ready.
//   On accept (registered):
//     - lane[sel] <= in_data; out_valid[sel] <= 1.
//     - sel <= (sel == N_LANES-1) ? 0 : sel+1. Wrap is explicit and does not rely on modulo-2^SEL_W.
//     - frame_done <= (sel == N_LANES-1); otherwise frame_done <= 0 each cycle.
//   Output handshake, per lane k:
//     - If out_valid[k] & out_ready[k] and there is no refill into k, then out_valid[k] <= 0.
//     - Simultaneous drain and refill of lane sel: new word loaded, out_valid stays 1, no bubble.
//     - out_ready[k] with out_valid[k]=0 is ignored.
//     - out_data[k] holds its value until overwritten by a refill; it is not cleared on drain.
//   Latency: an accepted word is visible on out_data/out_valid 1 cycle after accept.
//   Ordering: lane order is strictly 0,1,...,N_LANES-1,0,...
//     - A full sel lane stalls the input (in_ready=0). The block never skips to a free lane.
//   ena=0: in_ready=0; sel is held; lanes still drain via out_ready; frame_done stays 0.
//   in_valid=0: no state change apart from drains.
//   All lanes full: only the drain of lane sel reopens input.
// TESTING
//   1. Reset, defaults: rst=1 for 2 cycles, ena=1
//      -> out_valid=0000, sel=0, frame_done=0, in_ready=1.
//   2. Fill: out_ready=0000; send A0,A1,A2,A3 back-to-back
//      -> lanes 0..3 = A0..A3, out_valid=1111, sel=0.
//      -> frame_done high exactly 1 cycle (the cycle after A3), then in_ready=0.
//   3. Refill: from the fill state, out_ready=0001 and in_valid=1 with B0 for 1 cycle
//      -> lane0=B0, out_valid stays 1111, sel=1, lanes 1..3 unchanged.
//   4. Disable: ena=0, in_valid=1, out_ready=1111
//      -> in_ready=0, sel unchanged, out_valid=0000 next cycle, out_data unchanged.
//   5. Reset mid-frame: accept C0,C1, assert rst 1 cycle, then send D0
//      -> out_valid=0001, lane0=D0, sel=1.
//   6. N_LANES=3, out_ready=111, stream 7 words
//      -> sel sequence 0,1,2,0,1,2,0 with no stall; frame_done pulses twice.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: round-robin time-division demultiplexer.
// One valid/ready word stream is dealt out to N_LANES one-entry lane registers,
// strictly in lane order 0,1,...,N_LANES-1,0,... Each lane has its own
// valid/ready output handshake. A full target lane stalls the input; the
// block never skips ahead to a free lane.
module tdm_demux #(
  parameter  int N_LANES = 4,
  parameter  int WIDTH   = 8,
  localparam int SEL_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_LANES*WIDTH-1:0] out_data,
  output logic [N_LANES-1:0]       out_valid,
  input  logic [N_LANES-1:0]       out_ready,
  output logic [SEL_W-1:0]         sel,
  output logic                     frame_done
);

  // Index of the last lane; the pointer wraps explicitly here so that lane
  // counts which are not a power of two never reach an unused pointer value.
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_LANES - 1);

  logic [SEL_W-1:0]   r_sel;
  logic               r_frame_done;

  // Per-lane decode: which lane the pointer targets, and whether that lane
  // can take a word this cycle (empty, or being drained right now).
  logic [N_LANES-1:0] w_lane_hit;
  logic [N_LANES-1:0] w_lane_open;
  logic [N_LANES-1:0] w_lane_load;
  logic               w_sel_open;
  logic               w_accept;
  logic               w_sel_last;

  // Only the pointed-to lane matters for input readiness.
  assign w_sel_open = |(w_lane_hit & w_lane_open);
  assign in_ready   = ena & w_sel_open;
  assign w_accept   = in_valid & in_ready;
  assign w_sel_last = (r_sel == LAST_LANE);

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] r_lane_data;
      logic             r_lane_valid;

      assign w_lane_hit[gi]  = (r_sel == SEL_W'(gi));
      assign w_lane_open[gi] = ~r_lane_valid | out_ready[gi];
      assign w_lane_load[gi] = w_accept & w_lane_hit[gi];

      // Lane holding register: a refill wins over a drain so a lane that is
      // drained and refilled in the same cycle stays valid with no bubble.
      // Data is left in place on drain; only a refill or reset changes it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_lane_data  <= '0;
          r_lane_valid <= 1'b0;
        end else if (w_lane_load[gi]) begin
          r_lane_data  <= in_data;
          r_lane_valid <= 1'b1;
        end else if (r_lane_valid && out_ready[gi]) begin
          r_lane_valid <= 1'b0;
        end
      end

      assign out_data[gi*WIDTH +: WIDTH] = r_lane_data;
      assign out_valid[gi]               = r_lane_valid;
    end
  endgenerate

  // Lane pointer and end-of-frame pulse; both advance only on an accepted word,
  // so ena=0 or in_valid=0 freezes the pointer and keeps frame_done low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept & w_sel_last;
      if (w_accept) begin
        r_sel <= w_sel_last ? '0 : r_sel + SEL_W'(1);
      end
    end
  end

  assign sel        = r_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: a 4-lane and a 3-lane instance share the input stream.
// A behavioural model tracks each lane's contents; outputs are compared every
// cycle, and directed sequences pin the model with literal expectations.
module tb_tdm_demux;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [3:0]  out_ready;

  logic        in_ready4, fd4;
  logic [31:0] out_data4;
  logic [3:0]  out_valid4;
  logic [1:0]  sel4;

  logic        in_ready3, fd3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [1:0]  sel3;

  tdm_demux #(.N_LANES(4), .WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .ena(ena),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .sel(sel4), .frame_done(fd4)
  );

  tdm_demux #(.N_LANES(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .ena(ena),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready[2:0]),
    .sel(sel3), .frame_done(fd3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: lane contents, lane-full flags, next-lane pointer.
  bit         m_init = 1'b0;
  logic [7:0] m_data  [2][4];
  bit         m_valid [2][4];
  int         m_sel   [2];
  bit         m_fd    [2];

  function automatic int nl(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  // Model update on each rising edge from the inputs held over the past cycle.
  initial begin
    forever begin
      @(posedge clk);
      m_init = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          for (int k = 0; k < 4; k++) begin
            m_data[i][k]  = 8'h00;
            m_valid[i][k] = 1'b0;
          end
          m_sel[i] = 0;
          m_fd[i]  = 1'b0;
        end else begin
          bit acc;
          int s;
          s   = m_sel[i];
          acc = in_valid && ena && (!m_valid[i][s] || out_ready[s]);
          for (int k = 0; k < nl(i); k++) begin
            if (acc && k == s) begin
              m_data[i][k]  = in_data;
              m_valid[i][k] = 1'b1;
            end else if (m_valid[i][k] && out_ready[k]) begin
              m_valid[i][k] = 1'b0;
            end
          end
          m_fd[i] = acc && (s == nl(i) - 1);
          if (acc) begin
            if (i == 0) $display("accept n4 lane=%0d data=%02h t=%0t", s, in_data, $time);
            m_sel[i] = (s + 1) % nl(i);
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        for (int i = 0; i < 2; i++) begin
          logic [31:0] ev, ed, av, ad, as, af, ar;
          logic        er;
          ev = '0;
          ed = '0;
          for (int k = 0; k < nl(i); k++) begin
            ev[k]       = m_valid[i][k];
            ed[k*8 +: 8] = m_data[i][k];
          end
          er = ena && (!m_valid[i][m_sel[i]] || out_ready[m_sel[i]]);
          av = (i == 0) ? 32'(out_valid4) : 32'(out_valid3);
          ad = (i == 0) ? out_data4 : 32'(out_data3);
          as = (i == 0) ? 32'(sel4) : 32'(sel3);
          af = (i == 0) ? 32'(fd4) : 32'(fd3);
          ar = (i == 0) ? 32'(in_ready4) : 32'(in_ready3);
          check((i == 0) ? "n4_valid" : "n3_valid", av, ev);
          check((i == 0) ? "n4_data"  : "n3_data",  ad, ed);
          check((i == 0) ? "n4_sel"   : "n3_sel",   as, 32'(m_sel[i]));
          check((i == 0) ? "n4_frame" : "n3_frame", af, 32'(m_fd[i]));
          check((i == 0) ? "n4_ready" : "n3_ready", ar, 32'(er));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq3 [7] = '{0, 1, 2, 0, 1, 2, 0};
  int fdcnt;

  initial begin
    rst       = 1'b1;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 4'h0;

    // Reset defaults
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t1_valid", 32'(out_valid4), 32'h0);
    check("t1_sel",   32'(sel4),       32'h0);
    check("t1_frame", 32'(fd4),        32'h0);
    check("t1_ready", 32'(in_ready4),  32'h1);

    // Fill all four lanes back-to-back
    tick();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_valid", 32'(out_valid4), 32'hF);
    check("t2_sel",   32'(sel4),       32'h0);
    check("t2_frame", 32'(fd4),        32'h1);
    check("t2_data",  out_data4,       32'hA3A2A1A0);
    tick();
    @(negedge clk);
    check("t2_frame_off", 32'(fd4),       32'h0);
    check("t2_stall",     32'(in_ready4), 32'h0);

    // Drain-and-refill of lane 0
    tick();
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_data   = 8'hB0;
    @(negedge clk);
    check("t3_ready", 32'(in_ready4), 32'h1);
    tick();
    in_valid  = 1'b0;
    out_ready = 4'h0;
    @(negedge clk);
    check("t3_valid", 32'(out_valid4), 32'hF);
    check("t3_sel",   32'(sel4),       32'h1);
    check("t3_data",  out_data4,       32'hA3A2A1B0);

    // Disabled input, outputs drain
    tick();
    ena       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 4'hF;
    @(negedge clk);
    check("t4_ready", 32'(in_ready4), 32'h0);
    tick();
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    @(negedge clk);
    check("t4_valid", 32'(out_valid4), 32'h0);
    check("t4_sel",   32'(sel4),       32'h1);
    check("t4_data",  out_data4,       32'hA3A2A1B0);

    // Reset in the middle of a frame
    tick();
    in_valid = 1'b1;
    in_data  = 8'hC0;
    tick();
    in_data  = 8'hC1;
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hD0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(out_valid4), 32'h1);
    check("t5_sel",   32'(sel4),       32'h1);
    check("t5_data",  out_data4,       32'h000000D0);

    // Three-lane stream with consumers always ready
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 4'h7;
    fdcnt     = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 7);
      in_data  = 8'h30 + 8'(k);
      @(negedge clk);
      if (k < 7) begin
        check("t6_sel",   32'(sel3),      32'(seq3[k]));
        check("t6_ready", 32'(in_ready3), 32'h1);
      end
      if (k > 0) fdcnt += int'(fd3);
      tick();
    end
    check("t6_frames", 32'(fdcnt), 32'h2);

    // Randomized traffic checked by the per-cycle model comparison
    in_valid  = 1'b0;
    out_ready = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      ena      = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 9) < 4);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
